// File: rtl/regfile_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter_if
// Purpose: groups every bus-level signal of the register file port arbiter.
// It carries the two requester command channels (A = scheduler/ALU issue,
// B = memory-load writeback), the single byte-wide register file port, the
// shared completion channel and the busy flag.
// Ports (signals):
//   a_*/b_*     : valid/ready handshake plus write, wide, reg, wdata fields
//   rf_*        : address, write enable, write data, combinational read data
//   resp_*      : one-cycle completion pulse, requester id, read result
//   busy        : arbiter is in the middle of a command
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters + register file)
// ---------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
  parameter int REG_BITS   = 8,
  parameter int LOG2_NREGS = 3
);
  logic                    a_valid;
  logic                    a_ready;
  logic                    a_write;
  logic                    a_wide;
  logic [LOG2_NREGS-1:0]   a_reg;
  logic [2*REG_BITS-1:0]   a_wdata;

  logic                    b_valid;
  logic                    b_ready;
  logic                    b_write;
  logic                    b_wide;
  logic [LOG2_NREGS-1:0]   b_reg;
  logic [2*REG_BITS-1:0]   b_wdata;

  logic [LOG2_NREGS-1:0]   rf_addr;
  logic                    rf_we;
  logic [REG_BITS-1:0]     rf_wdata;
  logic [REG_BITS-1:0]     rf_rdata;

  logic                    resp_valid;
  logic                    resp_id;
  logic [2*REG_BITS-1:0]   resp_rdata;

  logic                    busy;

  modport slave (
    input  a_valid, a_write, a_wide, a_reg, a_wdata,
    output a_ready,
    input  b_valid, b_write, b_wide, b_reg, b_wdata,
    output b_ready,
    output rf_addr, rf_we, rf_wdata,
    input  rf_rdata,
    output resp_valid, resp_id, resp_rdata,
    output busy
  );

  modport master (
    output a_valid, a_write, a_wide, a_reg, a_wdata,
    input  a_ready,
    output b_valid, b_write, b_wide, b_reg, b_wdata,
    input  b_ready,
    input  rf_addr, rf_we, rf_wdata,
    output rf_rdata,
    input  resp_valid, resp_id, resp_rdata,
    input  busy
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
// Purpose: shares the single byte-wide register file port between requester
// A (scheduler/ALU issue) and requester B (memory-load writeback). Each
// command is a byte access or a register-pair access; pair accesses are split
// into a low-byte cycle at reg followed by a high-byte cycle at reg+1
// (wrapping to 0). Completion is reported one cycle after the last access on
// a shared response channel tagged with the requester id.
// Ports:
//   clk   : clock, everything updates on its rising edge
//   reset : synchronous, active-high reset
//   bus   : regfile_port_arbiter_if.slave (command channels, rf port,
//           response channel, busy)
// ---------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int REG_BITS   = 8,
  parameter int LOG2_NREGS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic                    r_lastGrant;
  logic                    r_write;
  logic                    r_wide;
  logic                    r_id;
  logic [LOG2_NREGS-1:0]   r_reg;
  logic [2*REG_BITS-1:0]   r_wdata;
  logic [REG_BITS-1:0]     r_loByte;

  logic                    r_respValid;
  logic                    r_respId;
  logic [2*REG_BITS-1:0]   r_respRdata;

  logic                    w_idle;
  logic                    w_aReady;
  logic                    w_bReady;
  logic                    w_accept;
  logic [LOG2_NREGS-1:0]   w_hiReg;

  // Round-robin grant: r_lastGrant is 1 when B won last, so on a tie the
  // other requester wins. A requester alone is always granted while idle,
  // which makes the two readies mutually exclusive by construction.
  assign w_idle   = (r_state == S_IDLE);
  assign w_aReady = w_idle & bus.a_valid & (~bus.b_valid | r_lastGrant);
  assign w_bReady = w_idle & bus.b_valid & (~bus.a_valid | ~r_lastGrant);
  assign w_accept = w_aReady | w_bReady;

  // The high half of a pair lives in the next register; the natural
  // overflow of the index width gives the 7 -> 0 wrap for free.
  assign w_hiReg  = r_reg + LOG2_NREGS'(1);

  assign bus.a_ready    = w_aReady;
  assign bus.b_ready    = w_bReady;
  assign bus.resp_valid = r_respValid;
  assign bus.resp_id    = r_respId;
  assign bus.resp_rdata = r_respRdata;
  assign bus.busy       = ~w_idle;

  // State register. Reset drops any in-flight command straight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and register file port drive. The port is parked at zero in
  // IDLE so the register file never sees a stray write between commands.
  always_comb begin
    w_nextState  = r_state;
    bus.rf_addr  = '0;
    bus.rf_we    = 1'b0;
    bus.rf_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nextState = S_LO;
        end
      end
      S_LO: begin
        bus.rf_addr  = r_reg;
        bus.rf_we    = r_write;
        bus.rf_wdata = r_wdata[REG_BITS-1:0];
        w_nextState  = r_wide ? S_HI : S_IDLE;
      end
      S_HI: begin
        bus.rf_addr  = w_hiReg;
        bus.rf_we    = r_write;
        bus.rf_wdata = r_wdata[2*REG_BITS-1:REG_BITS];
        w_nextState  = S_IDLE;
      end
      default: begin
        w_nextState  = S_IDLE;
      end
    endcase
  end

  // Command latch. Fields are sampled only at accept time, so requesters may
  // change them freely once their ready has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
      r_write     <= 1'b0;
      r_wide      <= 1'b0;
      r_id        <= 1'b0;
      r_reg       <= '0;
      r_wdata     <= '0;
    end else if (w_accept) begin
      r_lastGrant <= w_bReady;
      r_id        <= w_bReady;
      r_write     <= w_bReady ? bus.b_write : bus.a_write;
      r_wide      <= w_bReady ? bus.b_wide  : bus.a_wide;
      r_reg       <= w_bReady ? bus.b_reg   : bus.a_reg;
      r_wdata     <= w_bReady ? bus.b_wdata : bus.a_wdata;
    end
  end

  // The low byte of a pair read has to survive into the HI cycle, where it
  // is merged with the high byte to form the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loByte <= '0;
    end else if (r_state == S_LO) begin
      r_loByte <= bus.rf_rdata;
    end
  end

  // Response channel. The pulse is registered off the final access cycle so
  // it lands in the following IDLE cycle; id and data are zero whenever the
  // pulse is low, and read data is forced to zero for writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respId    <= 1'b0;
      r_respRdata <= '0;
    end else begin
      r_respValid <= 1'b0;
      r_respId    <= 1'b0;
      r_respRdata <= '0;
      if (r_state == S_LO && !r_wide) begin
        r_respValid <= 1'b1;
        r_respId    <= r_id;
        r_respRdata <= r_write ? '0 : {{REG_BITS{1'b0}}, bus.rf_rdata};
      end else if (r_state == S_HI) begin
        r_respValid <= 1'b1;
        r_respId    <= r_id;
        r_respRdata <= r_write ? '0 : {bus.rf_rdata, r_loByte};
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
// Purpose: self-checking bench for regfile_port_arbiter. It owns a small
// register file attached to the arbiter's port and a command-level reference
// model: every accepted command is applied atomically to a shadow register
// array, and its response and occupancy are predicted from the fixed
// accept-to-response latencies and the round-robin tie rule.
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;

  logic clk;
  logic reset;

  regfile_port_arbiter_if #(.REG_BITS(8), .LOG2_NREGS(3)) bus ();

  regfile_port_arbiter #(.REG_BITS(8), .LOG2_NREGS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side register file with a preload path used only while the
  // arbiter is idle, so initial contents are known to the model.
  logic [7:0] rfMem [8];
  logic       preEn;
  logic [2:0] preIdx;
  logic [7:0] preVal;

  always_ff @(posedge clk) begin
    if (preEn) begin
      rfMem[preIdx] <= preVal;
    end else if (bus.rf_we) begin
      rfMem[bus.rf_addr] <= bus.rf_wdata;
    end
  end

  assign bus.rf_rdata = rfMem[bus.rf_addr];

  // Reference model state.
  logic [7:0]  shadow [8];
  int          mBusy;
  int          mCd;
  bit          mLast;
  bit          expA;
  bit          expB;
  bit          accA;
  bit          accB;
  bit          expId;
  logic [15:0] expRdata;

  // Values observed in the most recent cycle, for directed checks.
  logic [2:0]  obsAddr;
  logic        obsWe;
  logic [7:0]  obsWdata;
  logic        obsRespValid;
  logic [15:0] obsRdata;
  logic        obsAReady;
  logic        obsBReady;

  int compCnt;
  int failCnt;

  // Single comparison point: counts it, and reports a failure if any.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compCnt++;
    assert (observed === expected) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Apply one accepted command to the shadow registers at command level and
  // predict its response and how long the arbiter stays occupied.
  task automatic applyCommand(input bit id, input bit write, input bit wide,
                              input logic [2:0] rg, input logic [15:0] wd);
    logic [2:0] r1;
    r1 = rg + 3'd1;
    if (write) begin
      shadow[rg] = wd[7:0];
      if (wide) shadow[r1] = wd[15:8];
      expRdata = 16'h0000;
    end else begin
      expRdata = wide ? {shadow[r1], shadow[rg]} : {8'h00, shadow[rg]};
    end
    expId = id;
    mLast = id;
    mBusy = wide ? 2 : 1;
    mCd   = wide ? 3 : 2;
  endtask

  // One clock cycle: check outputs against the model at the falling edge,
  // then advance the model at the rising edge.
  task automatic cycle();
    bit idle;
    @(negedge clk);
    idle = (mBusy == 0);
    expA = idle && bus.a_valid && (!bus.b_valid || mLast);
    expB = idle && bus.b_valid && (!bus.a_valid || !mLast);
    checkOutput("a_ready", 16'(bus.a_ready), 16'(expA));
    checkOutput("b_ready", 16'(bus.b_ready), 16'(expB));
    checkOutput("busy", 16'(bus.busy), 16'(!idle));
    checkOutput("resp_valid", 16'(bus.resp_valid), 16'(mCd == 1));
    if (mCd == 1) begin
      checkOutput("resp_id", 16'(bus.resp_id), 16'(expId));
      checkOutput("resp_rdata", bus.resp_rdata, expRdata);
    end
    if (idle) checkOutput("rf_we_idle", 16'(bus.rf_we), 16'h0000);
    obsAddr      = bus.rf_addr;
    obsWe        = bus.rf_we;
    obsWdata     = bus.rf_wdata;
    obsRespValid = bus.resp_valid;
    obsRdata     = bus.resp_rdata;
    obsAReady    = bus.a_ready;
    obsBReady    = bus.b_ready;
    @(posedge clk);
    if (mBusy > 0) mBusy--;
    if (mCd > 0) mCd--;
    accA = expA;
    accB = expB;
    if (expA) applyCommand(1'b0, bus.a_write, bus.a_wide, bus.a_reg, bus.a_wdata);
    if (expB) applyCommand(1'b1, bus.b_write, bus.b_wide, bus.b_reg, bus.b_wdata);
    #1;
  endtask

  // Preload one register while the arbiter is idle.
  task automatic writeReg(input logic [2:0] idx, input logic [7:0] val);
    preEn  = 1'b1;
    preIdx = idx;
    preVal = val;
    shadow[idx] = val;
    cycle();
    preEn  = 1'b0;
  endtask

  // One reset cycle; the model forgets any in-flight command.
  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mBusy = 0;
    mCd   = 0;
    mLast = 1'b1;
    accA  = 1'b0;
    accB  = 1'b0;
  endtask

  // Drive new command fields on a requester unless it is holding a command
  // that has not been accepted yet.
  task automatic applyStimulus(input bit enA, input bit enB, input bit narrowRead);
    if (!(bus.a_valid && !accA)) begin
      bus.a_valid = enA && (narrowRead || $urandom_range(0, 3) != 0);
      bus.a_write = narrowRead ? 1'b0 : 1'($urandom_range(0, 1));
      bus.a_wide  = narrowRead ? 1'b0 : 1'($urandom_range(0, 1));
      bus.a_reg   = 3'($urandom_range(0, 7));
      bus.a_wdata = 16'($urandom);
    end
    if (!(bus.b_valid && !accB)) begin
      bus.b_valid = enB && (narrowRead || $urandom_range(0, 3) != 0);
      bus.b_write = narrowRead ? 1'b0 : 1'($urandom_range(0, 1));
      bus.b_wide  = narrowRead ? 1'b0 : 1'($urandom_range(0, 1));
      bus.b_reg   = 3'($urandom_range(0, 7));
      bus.b_wdata = 16'($urandom);
    end
  endtask

  // Command helpers for the directed steps.
  task automatic setA(input bit v, input bit w, input bit wd, input logic [2:0] r,
                      input logic [15:0] d);
    bus.a_valid = v; bus.a_write = w; bus.a_wide = wd; bus.a_reg = r; bus.a_wdata = d;
  endtask

  task automatic setB(input bit v, input bit w, input bit wd, input logic [2:0] r,
                      input logic [15:0] d);
    bus.b_valid = v; bus.b_write = w; bus.b_wide = wd; bus.b_reg = r; bus.b_wdata = d;
  endtask

  // Directed steps followed by a randomized run, all in one sequence.
  initial begin
    int nAcc;
    compCnt = 0;
    failCnt = 0;
    preEn   = 1'b0;
    preIdx  = '0;
    preVal  = '0;
    accA    = 1'b0;
    accB    = 1'b0;
    setA(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    setB(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    // Reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_busy", 16'(bus.busy), 16'h0000);
    checkOutput("reset_resp_valid", 16'(bus.resp_valid), 16'h0000);
    checkOutput("reset_resp_id", 16'(bus.resp_id), 16'h0000);
    checkOutput("reset_resp_rdata", bus.resp_rdata, 16'h0000);
    checkOutput("reset_rf_we", 16'(bus.rf_we), 16'h0000);
    @(posedge clk);
    #1;
    mBusy = 0;
    mCd   = 0;
    mLast = 1'b1;
    for (int i = 0; i < 8; i++) writeReg(3'(i), 8'($urandom));
    writeReg(3'd6, 8'h34);
    writeReg(3'd7, 8'h12);
    reset = 1'b0;

    // A narrow write to r3.
    setA(1'b1, 1'b1, 1'b0, 3'd3, 16'h005A);
    cycle();
    bus.a_valid = 1'b0;
    cycle();
    checkOutput("t1_rf_we", 16'(obsWe), 16'h0001);
    checkOutput("t1_rf_addr", 16'(obsAddr), 16'h0003);
    checkOutput("t1_rf_wdata", 16'(obsWdata), 16'h005A);
    cycle();
    checkOutput("t1_resp_valid", 16'(obsRespValid), 16'h0001);
    checkOutput("t1_resp_rdata", obsRdata, 16'h0000);

    // A wide read of r6/r7.
    setA(1'b1, 1'b0, 1'b1, 3'd6, 16'h0000);
    cycle();
    bus.a_valid = 1'b0;
    cycle();
    checkOutput("t2_lo_addr", 16'(obsAddr), 16'h0006);
    checkOutput("t2_lo_we", 16'(obsWe), 16'h0000);
    cycle();
    checkOutput("t2_hi_addr", 16'(obsAddr), 16'h0007);
    checkOutput("t2_hi_we", 16'(obsWe), 16'h0000);
    cycle();
    checkOutput("t2_resp_rdata", obsRdata, 16'h1234);

    // B wide write wrapping from r7 to r0.
    setB(1'b1, 1'b1, 1'b1, 3'd7, 16'hBEEF);
    cycle();
    bus.b_valid = 1'b0;
    repeat (3) cycle();
    checkOutput("t3_r7", 16'(rfMem[7]), 16'h00EF);
    checkOutput("t3_r0", 16'(rfMem[0]), 16'h00BE);

    // Both requesters held with narrow reads: strict alternation.
    setA(1'b1, 1'b0, 1'b0, 3'd1, 16'h0000);
    setB(1'b1, 1'b0, 1'b0, 3'd5, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checkOutput("t4_both_ready", 16'(obsAReady & obsBReady), 16'h0000);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (3) cycle();

    // Reset during the HI cycle of a wide write to r2/r3.
    setA(1'b1, 1'b1, 1'b1, 3'd2, 16'h7788);
    cycle();
    bus.a_valid = 1'b0;
    cycle();
    applyReset();
    checkOutput("t5_r2_kept", 16'(rfMem[2]), 16'h0088);
    cycle();
    writeReg(3'd3, 8'hC3);
    setA(1'b1, 1'b0, 1'b0, 3'd4, 16'h0000);
    setB(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000);
    cycle();
    checkOutput("t5_tie_to_a", 16'(obsAReady), 16'h0001);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (4) cycle();

    // B alone, back-to-back narrow reads.
    nAcc = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      cycle();
      if (obsBReady) begin
        if (nAcc > 0) checkOutput("t6_accept_with_resp", 16'(obsRespValid), 16'h0001);
        nAcc++;
      end
    end
    bus.b_valid = 1'b0;
    repeat (3) cycle();
    checkOutput("t6_accept_count", 16'(nAcc), 16'd6);

    // Randomized mixed traffic from both requesters.
    accA = 1'b0;
    accB = 1'b0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      cycle();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("final_r%0d", i), 16'(rfMem[i]), 16'(shadow[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end

endmodule
